// File: rtl/int2ieee_sched_pkg.sv
// Shared constants and types for the int2ieee request scheduler.
package int2ieee_sched_pkg;
   localparam int unsigned DefNumReq    = 4;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefLatency   = 2;

   typedef logic [31:0] stat_cnt_t;
endpackage

// File: rtl/int2ieee.sv
// Signed integer to IEEE 754 converter, round-to-nearest-even, Latency register stages.
// DataWidth 16/32/64 selects binary16/binary32/binary64 output format.
module int2ieee #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Latency   = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DataWidth-1:0] int_i,
   output logic [DataWidth-1:0] ieee_o
);
   localparam int unsigned ExpW = (DataWidth == 64) ? 11 : (DataWidth == 16) ? 5 : 8;
   localparam int unsigned ManW = DataWidth - 1 - ExpW;
   localparam int unsigned PosW = $clog2(DataWidth);
   localparam logic [ExpW-1:0] Bias = ExpW'((1 << (ExpW - 1)) - 1);

   logic                 w_sign;
   logic [DataWidth-1:0] w_mag;
   logic [DataWidth-1:0] w_norm;
   logic [PosW-1:0]      w_pos;
   logic                 w_rnd;
   logic [DataWidth-2:0] w_body;
   logic [DataWidth-1:0] w_conv;

   always_comb begin
      w_sign = int_i[DataWidth-1];
      w_mag  = w_sign ? (~int_i + 1'b1) : int_i;
      w_pos  = '0;
      for (int i = 0; i < DataWidth; i++) begin
         if (w_mag[i]) w_pos = PosW'(i);
      end
      w_norm = w_mag << (PosW'(DataWidth - 1) - w_pos);
      // guard bit and sticky bits below the mantissa; tie rounds to even
      w_rnd  = w_norm[DataWidth-2-ManW] &
               ((|w_norm[DataWidth-3-ManW:0]) | w_norm[DataWidth-1-ManW]);
      w_body = {Bias + ExpW'(w_pos), w_norm[DataWidth-2 -: ManW]} + (DataWidth-1)'(w_rnd);
      w_conv = w_norm[DataWidth-1] ? {w_sign, w_body} : '0;
   end

   if (Latency == 0) begin : g_comb
      logic w_unused;
      assign w_unused = clk_i ^ rst_ni;
      assign ieee_o   = w_conv;
   end else begin : g_pipe
      logic [DataWidth-1:0] r_pipe [Latency];
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) r_pipe[i] <= '0;
         end else begin
            r_pipe[0] <= w_conv;
            for (int i = 1; i < Latency; i++) r_pipe[i] <= r_pipe[i-1];
         end
      end
      assign ieee_o = r_pipe[Latency-1];
   end
endmodule

// File: rtl/int2ieee_rr_arb.sv
// Round-robin arbiter: grant from valid only, pointer advances past the winner when enabled.
module int2ieee_rr_arb
   import int2ieee_sched_pkg::*;
#(
   parameter int unsigned NumReq = DefNumReq
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumReq-1:0]         valid_i,
   input  logic                      en_i,
   output logic [NumReq-1:0]         gnt_o,
   output logic [$clog2(NumReq)-1:0] gnt_idx_o,
   output logic                      gnt_any_o
);
   localparam int unsigned IdW = $clog2(NumReq);

   logic [IdW-1:0] r_ptr;
   logic [IdW-1:0] w_idx;
   logic           w_any;

   function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base, input int unsigned off);
      int unsigned s;
      s = base + off;
      if (s >= NumReq) s = s - NumReq;
      return IdW'(s);
   endfunction

   always_comb begin
      w_any = 1'b0;
      w_idx = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (!w_any && valid_i[wrap_add(r_ptr, k)]) begin
            w_any = 1'b1;
            w_idx = wrap_add(r_ptr, k);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_ptr <= '0;
      else if (en_i && w_any) r_ptr <= wrap_add(w_idx, 1);
   end

   assign gnt_o     = w_any ? (NumReq'(1) << w_idx) : '0;
   assign gnt_idx_o = w_idx;
   assign gnt_any_o = w_any;
endmodule

// File: rtl/int2ieee_scheduler.sv
// Shares one int2ieee converter among NumReq requesters with credit-based output buffering.
// Define INT2IEEE_SCHEDULER_STATS_EN to add the issue/stall statistics counters.
module int2ieee_scheduler
   import int2ieee_sched_pkg::*;
#(
   parameter int unsigned NumReq    = DefNumReq,
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned Latency   = DefLatency,
   parameter int unsigned FifoDepth = Latency + 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumReq-1:0]                 req_valid_i,
   output logic [NumReq-1:0]                 req_ready_o,
   input  logic [NumReq-1:0][DataWidth-1:0]  req_int_i,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [DataWidth-1:0]              rsp_ieee_o,
   output logic [$clog2(NumReq)-1:0]         rsp_id_o,
   output logic                              busy_o
`ifdef INT2IEEE_SCHEDULER_STATS_EN
   ,
   output stat_cnt_t                         stat_issued_o,
   output stat_cnt_t                         stat_stall_o
`endif
);
   localparam int unsigned IdW  = $clog2(NumReq);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CrW  = $clog2(FifoDepth + 1);

   logic [NumReq-1:0]    w_gnt;
   logic [IdW-1:0]       w_gnt_idx;
   logic                 w_gnt_any;
   logic                 w_credit_ok;
   logic                 w_issue;
   logic                 w_pop;
   logic                 w_push;
   logic [IdW-1:0]       w_push_id;
   logic [DataWidth-1:0] w_ieee;

   logic [CrW-1:0]       r_credits;
   logic [CrW-1:0]       r_fifo_cnt;
   logic [PtrW-1:0]      r_wr_ptr;
   logic [PtrW-1:0]      r_rd_ptr;
   logic [DataWidth-1:0] r_fifo_data [FifoDepth];
   logic [IdW-1:0]       r_fifo_id   [FifoDepth];

   // credits cover in-flight plus buffered results, so a granted issue always has a FIFO slot
   assign w_credit_ok = (r_credits < CrW'(FifoDepth));
   assign req_ready_o = w_gnt & {NumReq{w_credit_ok}};
   assign w_issue     = w_gnt_any & w_credit_ok;
   assign w_pop       = rsp_valid_o & rsp_ready_i;

   int2ieee_rr_arb #(.NumReq(NumReq)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (req_valid_i),
      .en_i      (w_credit_ok),
      .gnt_o     (w_gnt),
      .gnt_idx_o (w_gnt_idx),
      .gnt_any_o (w_gnt_any)
   );

   int2ieee #(.DataWidth(DataWidth), .Latency(Latency)) u_conv (
      .clk_i  (clk_i),
      .rst_ni (~rst_i),
      .int_i  (req_int_i[w_gnt_idx]),
      .ieee_o (w_ieee)
   );

   if (Latency == 0) begin : g_no_sr
      assign w_push    = w_issue;
      assign w_push_id = w_gnt_idx;
   end else begin : g_sr
      logic [Latency-1:0] r_sr_vld;
      logic [IdW-1:0]     r_sr_id [Latency];
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_sr_vld <= '0;
         end else begin
            r_sr_vld[0] <= w_issue;
            for (int i = 1; i < Latency; i++) r_sr_vld[i] <= r_sr_vld[i-1];
         end
      end
      always_ff @(posedge clk_i) begin
         r_sr_id[0] <= w_gnt_idx;
         for (int i = 1; i < Latency; i++) r_sr_id[i] <= r_sr_id[i-1];
      end
      assign w_push    = r_sr_vld[Latency-1];
      assign w_push_id = r_sr_id[Latency-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
         r_credits  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
         case ({w_issue, w_pop})
            2'b10:   r_credits <= r_credits + 1'b1;
            2'b01:   r_credits <= r_credits - 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_ieee;
         r_fifo_id[r_wr_ptr]   <= w_push_id;
      end
   end

   assign rsp_valid_o = (r_fifo_cnt != '0);
   assign rsp_ieee_o  = rsp_valid_o ? r_fifo_data[r_rd_ptr] : '0;
   assign rsp_id_o    = rsp_valid_o ? r_fifo_id[r_rd_ptr] : '0;
   assign busy_o      = (r_credits != '0);

`ifdef INT2IEEE_SCHEDULER_STATS_EN
   stat_cnt_t r_issued;
   stat_cnt_t r_stall;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_issued <= '0;
         r_stall  <= '0;
      end else begin
         if (w_issue) r_issued <= r_issued + 1'b1;
         if ((|req_valid_i) && !w_credit_ok) r_stall <= r_stall + 1'b1;
      end
   end
   assign stat_issued_o = r_issued;
   assign stat_stall_o  = r_stall;
`endif
endmodule

// File: doc/int2ieee_scheduler.md
INT2IEEE_SCHEDULER -- requirements
Module: int2ieee_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter DataWidth, default 32: operand and result width.
REQ-003 SHALL have parameter Latency, default 2: pipeline latency of the shared converter.
REQ-004 SHALL have parameter FifoDepth, default Latency+2: number of output buffer entries, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, NumReq bits: per-requester valid.
REQ-008 SHALL have port req_ready_o, output, NumReq bits: per-requester accept.
REQ-009 SHALL have port req_int_i, input, NumReq x DataWidth: signed integer operands.
REQ-010 SHALL have port rsp_valid_o, output, 1 bit: result available.
REQ-011 SHALL have port rsp_ready_i, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port rsp_ieee_o, output, DataWidth: IEEE 754 result.
REQ-013 SHALL have port rsp_id_o, output, $clog2(NumReq) bits: index of the requester that issued the result.
REQ-014 SHALL have port busy_o, output, 1 bit: high while any operation is in flight or buffered.

Function
REQ-015 SHALL grant at most one requester per cycle, round-robin: search starts at ptr; after a grant to index g, ptr becomes (g+1) mod NumReq; ptr is unchanged when there is no grant.
REQ-016 SHALL drive req_ready_o[g] high only for the granted index, and only when credits < FifoDepth; credits = in-flight count + FIFO occupancy.
REQ-017 SHALL compute the grant from req_valid_i only; req_ready_o SHALL NOT depend on rsp_ready_i in the same cycle.
REQ-018 SHALL treat a handshake (valid and ready both high) as an issue: the operand enters the converter and {valid, id} enter a shift register Latency stages long.
REQ-019 SHALL push {result, id} into the output FIFO when the shift register tail is valid; with Latency 0, the push happens in the issue cycle.
REQ-020 SHALL drive rsp_valid_o as FIFO not-empty and rsp_ieee_o/rsp_id_o as the FIFO head; first result appears Latency+1 cycles after issue.
REQ-021 SHALL hold rsp_ieee_o and rsp_id_o stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-022 SHALL update credits: +1 on issue, -1 on output handshake, unchanged when both occur in the same cycle; credits never exceed FifoDepth, so the FIFO never overflows.
REQ-023 SHALL preserve issue order on the output; there is no reordering.
REQ-024 SHALL drive busy_o = (credits != 0).
REQ-025 SHALL let a requester whose valid is dropped before grant lose no state; no request is latched without a handshake.

Reset
REQ-026 SHALL, with rst_i high at a clock edge, clear ptr, credits, the shift register valid bits, and FIFO pointers; outputs after reset: req_ready_o valid-gated per REQ-016, rsp_valid_o=0, busy_o=0, rsp_id_o=0, rsp_ieee_o=0.
REQ-027 SHALL discard all in-flight and buffered results on reset mid-operation; no result from before reset SHALL appear afterwards.
REQ-028 SHALL drive the converter's active-low reset from the inverse of rst_i; converter data need not be reset, since validity comes from the shift register.

Configuration
REQ-029 SHALL, with INT2IEEE_SCHEDULER_STATS_EN defined, provide outputs stat_issued_o (32 bit) and stat_stall_o (32 bit). stat_issued_o counts issues. stat_stall_o counts cycles where some req_valid_i is high but no issue occurs because credits == FifoDepth. Both counters wrap modulo 2^32 and reset to 0.
REQ-030 SHALL, without the macro, omit those ports and their counters entirely.

Structure
REQ-031 SHALL place the stats counter typedef (32-bit) and the default parameter constants in the shared package int2ieee_sched_pkg.
REQ-032 SHALL instantiate the existing INT2IEEE converter once as the shared datapath.
REQ-033 SHALL implement the round-robin grant as one sub-module, int2ieee_rr_arb, covering the pointer and the grant logic.

Verification
REQ-034 Single request: req 1 issues int 1, rsp_ready_i held high -> rsp_ieee_o=0x3F800000, rsp_id_o=1, exactly Latency+1 cycles after issue.
REQ-035 All four requesters valid continuously with ptr=0 -> grants in order 0,1,2,3,0; results -2→0xC0000000, 0→0x00000000, 16777217→0x4B800000 (round to nearest even), each tagged with the correct id.
REQ-036 rsp_ready_i held low, requests continuous -> exactly FifoDepth issues, then all req_ready_o=0 and busy_o=1; after rsp_ready_i rises, all results drain in order with no loss.
REQ-037 Output handshake in the same cycle as an issue with credits == FifoDepth-1 -> credits unchanged and the issue is accepted.
REQ-038 rst_i asserted for one cycle with 3 operations in flight -> no rsp_valid_o afterwards until a new issue; busy_o=0 on the cycle after reset.
REQ-039 With INT2IEEE_SCHEDULER_STATS_EN: 5 issues and 3 full-stall cycles -> stat_issued_o=5, stat_stall_o=3.
